tap_controller: RTL
===================

Name: tap_controller

Overview:
- IEEE 1149.1-style TAP controller that drives the data-register side of the JTAG interface: Capture_DR, Shift_DR, Update_DR and tdr_Select.
- Contains the 16-state TAP FSM, the instruction register (IR), instruction-to-TDR select decode and the TDO output mux.
- Sits between the chip-level JTAG pins (TMS/TDI/TDO) and the bank of test data registers, including the bypass DR.

Parameters:
- IR_LENGTH, 4, instruction register width in bits (≥2).
- NUM_TDR, 4, number of attached TDRs; index 0 is always the bypass DR.
- DR_ID_WIDTH, 2, width of the TDR index, equal to clog2(NUM_TDR).

Ports:
- TCK  input  1  test clock; all state changes on posedge TCK.
- RST  input  1  synchronous active-high reset.
- TMS  input  1  test mode select.
- TDI  input  1  serial data in.
- SO_DR_IN  input  NUM_TDR  serial outputs (MSB) of each TDR.
- TDO  output  1  serial data out.
- TDO_EN  output  1  high while in Shift-DR or Shift-IR.
- Capture_DR / Shift_DR / Update_DR  output  1 each  DR control strobes.
- Capture_IR / Shift_IR / Update_IR  output  1 each  IR state indicators, for debug and test.
- tdr_Select  output  NUM_TDR  one-hot TDR select.
- Instruction  output  IR_LENGTH  current (updated) instruction.
- Tap_State  output  4  current FSM state encoding.

Behaviour:
- One clock, TCK. RST is synchronous and active-high; it takes effect at posedge TCK.
- Reset values:
  - State = TEST_LOGIC_RESET.
  - Instruction = all ones (BYPASS).
  - IR shift register = all zeros.
  - tdr_Select = 1 (bypass).
  - All strobes 0; TDO = 0; TDO_EN = 0.
- FSM, written as next state for TMS=0 / TMS=1:
  - TLR: RTI / TLR
  - RTI: RTI / SEL_DR
  - SEL_DR: CAP_DR / SEL_IR
  - CAP_DR: SH_DR / EX1_DR
  - SH_DR: SH_DR / EX1_DR
  - EX1_DR: PAU_DR / UPD_DR
  - PAU_DR: PAU_DR / EX2_DR
  - EX2_DR: SH_DR / UPD_DR
  - UPD_DR: RTI / SEL_DR
  - SEL_IR: CAP_IR / TLR
  - The IR branch (CAP_IR … UPD_IR) mirrors the DR branch exactly.
  - Five consecutive TMS=1 clocks reach TLR from any state.
- Strobe outputs are Moore outputs decoded from the registered state:
  - Capture_DR = (state==CAP_DR); Shift_DR and Update_DR likewise.
  - Each TDR acts on the posedge at which its strobe is high.
  - Number of bits shifted = number of cycles spent in SH_DR or SH_IR.
- TLR state: Instruction is forced to all ones and tdr_Select to 1 on every cycle.
- IR shift register:
  - CAP_IR: at the posedge, load {zeros, 2'b01} (LSBs = 01).
  - SH_IR: shift left, TDI into the LSB.
  - UPD_IR: at the posedge, Instruction <= IR shift register.
- Instruction decode (combinational from Instruction):
  - All ones, or any code ≥ NUM_TDR other than all ones → tdr_Select = 1.
  - Code k in 1..NUM_TDR-1 → tdr_Select = 1<<k.
  - Code 0 → bypass.
- tdr_Select changes only after UPD_IR or TLR. It is stable throughout any DR scan.
- TDO:
  - SH_DR: the SO_DR_IN bit selected by tdr_Select.
  - SH_IR: IR shift register MSB.
  - Any other state: 0.
  - TDO is combinational from registered state and registers; TDO_EN is asserted in the same states.
- RST mid-scan: on the next posedge, state goes to TLR and IR contents are discarded. No Update strobe is issued.
- TMS is sampled only at posedge. No other inputs affect state transitions.

Decomposition:
- Shared header tap_defs.vh holds:
  - 4-bit state encodings (TLR=0 … UPD_IR=15) as localparam/define.
  - BYPASS code = all ones.
  - IR capture pattern 2'b01.
- Sub-module tap_fsm:
  - Contains the state register and next-state logic.
  - Outputs state plus the six strobes.
- tap_controller instantiates tap_fsm and adds the IR, decode and TDO mux.

Test Plan:
- Reset: RST=1 for 1 cycle → Tap_State=TLR, Instruction=4'b1111, tdr_Select=4'b0001, TDO_EN=0.
- TLR via TMS: from SH_DR, apply TMS=1 ×5 with RST=0 → TLR after exactly 5 posedges; no Update_DR pulse on the path EX1_DR→UPD_DR is allowed only if the state is passed, so check that Update_DR pulses once (EX1→UPD) and no TDR data is corrupted afterward.
- IR scan loading 4'b0010:
  - TMS 0,1,1,0,0 then shift 4 bits LSB-first-in with last TMS=1, then TMS 1,0.
  - Expected: TDO emits captured 0,0,0,1 (MSB first), Instruction=4'b0010, tdr_Select=4'b0100 after UPD_IR.
- Bypass DR scan with a 5-bit model on SO_DR_IN[0]:
  - CAP_DR, then 10 SH_DR cycles with TDI=1010000000.
  - Expected: TDO=11111 then 10100.
- Pause/resume: SH_DR 2 cycles → PAU_DR 3 cycles → EX2_DR → SH_DR 3 cycles.
  - Expected: exactly 5 Shift_DR-high cycles total; Shift_DR=0 during pause; TDO_EN=0 during pause.
- RST asserted during SH_IR after 2 bits: next cycle TLR, Instruction=all ones, Update_IR never pulses; an unknown code 4'b1000 loaded afterward → tdr_Select=4'b0001.

Source files
------------

// File: rtl/tap_controller_pkg.sv
// Shared TAP definitions: the 16-state encoding and the IR capture pattern.
package tap_controller_pkg;

  typedef enum logic [3:0] {
    TLR    = 4'd0,
    RTI    = 4'd1,
    SEL_DR = 4'd2,
    CAP_DR = 4'd3,
    SH_DR  = 4'd4,
    EX1_DR = 4'd5,
    PAU_DR = 4'd6,
    EX2_DR = 4'd7,
    UPD_DR = 4'd8,
    SEL_IR = 4'd9,
    CAP_IR = 4'd10,
    SH_IR  = 4'd11,
    EX1_IR = 4'd12,
    PAU_IR = 4'd13,
    EX2_IR = 4'd14,
    UPD_IR = 4'd15
  } tap_state_e;

  localparam logic [1:0] IR_CAPTURE = 2'b01;

endpackage

// File: rtl/tap_fsm.sv
// 16-state TAP state machine with Moore-decoded DR/IR strobes.
//   state  | meaning
//   TLR    | test-logic-reset, instruction held at BYPASS
//   RTI    | run-test/idle
//   SEL_*  | choose DR or IR branch
//   CAP_*  | capture into the selected register
//   SH_*   | shift one bit per TCK
//   EX1/2  | exit towards update or pause
//   PAU_*  | shift paused
//   UPD_*  | update strobe
module tap_fsm
  import tap_controller_pkg::*;
(
  input  logic       TCK,
  input  logic       RST,
  input  logic       TMS,
  output tap_state_e state,
  output logic       Capture_DR,
  output logic       Shift_DR,
  output logic       Update_DR,
  output logic       Capture_IR,
  output logic       Shift_IR,
  output logic       Update_IR
);

  tap_state_e state_q, state_d;

  always_ff @(posedge TCK) begin
    if (RST) state_q <= TLR;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:    state_d = TMS ? TLR    : RTI;
      RTI:    state_d = TMS ? SEL_DR : RTI;
      SEL_DR: state_d = TMS ? SEL_IR : CAP_DR;
      CAP_DR: state_d = TMS ? EX1_DR : SH_DR;
      SH_DR:  state_d = TMS ? EX1_DR : SH_DR;
      EX1_DR: state_d = TMS ? UPD_DR : PAU_DR;
      PAU_DR: state_d = TMS ? EX2_DR : PAU_DR;
      EX2_DR: state_d = TMS ? UPD_DR : SH_DR;
      UPD_DR: state_d = TMS ? SEL_DR : RTI;
      SEL_IR: state_d = TMS ? TLR    : CAP_IR;
      CAP_IR: state_d = TMS ? EX1_IR : SH_IR;
      SH_IR:  state_d = TMS ? EX1_IR : SH_IR;
      EX1_IR: state_d = TMS ? UPD_IR : PAU_IR;
      PAU_IR: state_d = TMS ? EX2_IR : PAU_IR;
      EX2_IR: state_d = TMS ? UPD_IR : SH_IR;
      UPD_IR: state_d = TMS ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  assign state      = state_q;
  assign Capture_DR = (state_q == CAP_DR);
  assign Shift_DR   = (state_q == SH_DR);
  assign Update_DR  = (state_q == UPD_DR);
  assign Capture_IR = (state_q == CAP_IR);
  assign Shift_IR   = (state_q == SH_IR);
  assign Update_IR  = (state_q == UPD_IR);

endmodule

// File: rtl/tap_controller.sv
// TAP controller top: FSM, instruction register, TDR select decode, TDO mux.
module tap_controller
  import tap_controller_pkg::*;
#(
  parameter int IR_LENGTH   = 4,
  parameter int NUM_TDR     = 4,
  parameter int DR_ID_WIDTH = 2
) (
  input  logic                 TCK,
  input  logic                 RST,
  input  logic                 TMS,
  input  logic                 TDI,
  input  logic [NUM_TDR-1:0]   SO_DR_IN,
  output logic                 TDO,
  output logic                 TDO_EN,
  output logic                 Capture_DR,
  output logic                 Shift_DR,
  output logic                 Update_DR,
  output logic                 Capture_IR,
  output logic                 Shift_IR,
  output logic                 Update_IR,
  output logic [NUM_TDR-1:0]   tdr_Select,
  output logic [IR_LENGTH-1:0] Instruction,
  output logic [3:0]           Tap_State
);

  tap_state_e state;

  tap_fsm u_fsm (
    .TCK        (TCK),
    .RST        (RST),
    .TMS        (TMS),
    .state      (state),
    .Capture_DR (Capture_DR),
    .Shift_DR   (Shift_DR),
    .Update_DR  (Update_DR),
    .Capture_IR (Capture_IR),
    .Shift_IR   (Shift_IR),
    .Update_IR  (Update_IR)
  );

  logic [IR_LENGTH-1:0]   ir_q, ir_d;
  logic [IR_LENGTH-1:0]   instr_q, instr_d;
  logic [DR_ID_WIDTH-1:0] tdr_idx;
  logic [NUM_TDR-1:0]     sel;

  always_ff @(posedge TCK) begin
    if (RST) begin
      ir_q    <= '0;
      instr_q <= '1;
    end else begin
      ir_q    <= ir_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    ir_d    = ir_q;
    instr_d = instr_q;
    case (state)
      CAP_IR: ir_d    = IR_LENGTH'(IR_CAPTURE);
      SH_IR:  ir_d    = {ir_q[IR_LENGTH-2:0], TDI};
      UPD_IR: instr_d = ir_q;
      TLR:    instr_d = '1;
      default: ;
    endcase
  end

  // Unknown codes and BYPASS both fall back to the bypass DR at index 0.
  always_comb begin
    tdr_idx = '0;
    sel     = NUM_TDR'(1);
    if ((instr_q != '1) && ({1'b0, instr_q} < (IR_LENGTH+1)'(NUM_TDR))) begin
      tdr_idx = instr_q[DR_ID_WIDTH-1:0];
      sel     = NUM_TDR'(1) << tdr_idx;
    end
  end

  always_comb begin
    TDO    = 1'b0;
    TDO_EN = 1'b0;
    if (state == SH_DR) begin
      TDO    = |(SO_DR_IN & sel);
      TDO_EN = 1'b1;
    end else if (state == SH_IR) begin
      TDO    = ir_q[IR_LENGTH-1];
      TDO_EN = 1'b1;
    end
  end

  assign tdr_Select  = sel;
  assign Instruction = instr_q;
  assign Tap_State   = state;

endmodule
